// File: rtl/soc_na_config_regs.sv
// Network-adapter configuration/status register file: Wishbone-classic slave with
// static tile parameters, compute-tile list, LFSR seed, cycle counter, scratch and CDC control.
module soc_na_config_regs #(
    parameter int unsigned      DW          = 32,
    parameter int unsigned      TILEID      = 0,
    parameter int unsigned      NUMTILES    = 1,
    parameter logic [1:0]       CONF_BITS   = 2'b00,
    parameter int unsigned      COREBASE    = 0,
    parameter int unsigned      NUMCORES    = 1,
    parameter int unsigned      NUMCTS      = 1,
    parameter int unsigned      MAX_CTS     = 64,
    parameter logic [MAX_CTS*16-1:0] CTLIST = '0,
    parameter int unsigned      NUM_SCRATCH = 4,
    parameter logic [31:0]      SEED_INIT   = 32'hACE1_2345,
    parameter logic [2:0]       CDC_DEFAULT = 3'd0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic          wb_we_i,
    input  logic [3:0]    wb_sel_i,
    input  logic [15:0]   wb_adr_i,
    input  logic [DW-1:0] wb_dat_i,
    output logic [DW-1:0] wb_dat_o,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    output logic          wb_rty_o,
    output logic [2:0]    cdc_conf,
    output logic          cdc_enable
);

    localparam int unsigned NUM_WORDS = MAX_CTS / 2;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [4095:0] CT_PAD  = 4096'(CTLIST);

    if (DW != 32) begin : g_bad_dw
        $fatal(1, "soc_na_config_regs: DW must be 32");
    end
    if (MAX_CTS < 2 || MAX_CTS > 256 || (MAX_CTS % 2) != 0) begin : g_bad_max_cts
        $fatal(1, "soc_na_config_regs: MAX_CTS must be even and in 2..256");
    end
    if (NUMCTS < 1 || NUMCTS > MAX_CTS) begin : g_bad_numcts
        $fatal(1, "soc_na_config_regs: NUMCTS must be in 1..MAX_CTS");
    end
    if (NUM_SCRATCH < 1 || NUM_SCRATCH > 16) begin : g_bad_scratch
        $fatal(1, "soc_na_config_regs: NUM_SCRATCH must be in 1..16");
    end
    if (SEED_INIT == 32'd0) begin : g_bad_seed
        $fatal(1, "soc_na_config_regs: SEED_INIT must be nonzero");
    end

    logic        req;
    logic        dec_ok;
    logic [31:0] dec_rdata;
    logic        wr_seed;
    logic        wr_cdc;
    logic        wr_scr;
    logic [31:0] lfsr;
    logic [31:0] lfsr_step;
    logic [31:0] cycle_cnt;
    logic [31:0] scratch [16];
    logic        unused_adr;

    assign unused_adr = ^wb_adr_i[1:0];
    assign wb_rty_o   = 1'b0;
    assign req        = wb_cyc_i & wb_stb_i & ~(wb_ack_o | wb_err_o);
    assign lfsr_step  = lfsr[0] ? ({1'b0, lfsr[31:1]} ^ LFSR_TAPS) : {1'b0, lfsr[31:1]};

    function automatic logic [15:0] ct_entry(input logic [7:0] idx);
        if ({24'd0, idx} < NUMCTS) return CT_PAD[{idx, 4'b0000} +: 16];
        return 16'd0;
    endfunction

    // dec_ok covers both existence of the address and legality of the access type
    always_comb begin
        dec_ok    = 1'b0;
        dec_rdata = '0;
        wr_seed   = 1'b0;
        wr_cdc    = 1'b0;
        wr_scr    = 1'b0;
        if (wb_adr_i[15:12] == 4'h0) begin
            case (wb_adr_i[11:2])
                10'h000: begin dec_ok = ~wb_we_i; dec_rdata = 32'(TILEID);        end
                10'h001: begin dec_ok = ~wb_we_i; dec_rdata = 32'(NUMTILES);      end
                10'h003: begin dec_ok = ~wb_we_i; dec_rdata = {30'd0, CONF_BITS}; end
                10'h004: begin dec_ok = ~wb_we_i; dec_rdata = 32'(COREBASE);      end
                10'h006: begin dec_ok = ~wb_we_i; dec_rdata = 32'(NUMCORES);      end
                10'h00A: begin dec_ok = ~wb_we_i; dec_rdata = 32'(NUMCTS);        end
                10'h00B: begin dec_ok = 1'b1;     dec_rdata = lfsr;      wr_seed = wb_we_i; end
                10'h00C: begin dec_ok = ~wb_we_i; dec_rdata = cycle_cnt;          end
                10'h050: begin dec_ok = ~wb_we_i; dec_rdata = 32'd1;              end
                10'h052: begin dec_ok = 1'b1;     dec_rdata = {29'd0, cdc_conf}; wr_cdc = wb_we_i; end
                default: begin
                    if (wb_adr_i[11:6] == 6'h04 && {28'd0, wb_adr_i[5:2]} < NUM_SCRATCH) begin
                        dec_ok    = 1'b1;
                        dec_rdata = scratch[wb_adr_i[5:2]];
                        wr_scr    = wb_we_i;
                    end else if (wb_adr_i[11:9] == 3'b001 && {25'd0, wb_adr_i[8:2]} < NUM_WORDS) begin
                        dec_ok    = ~wb_we_i;
                        dec_rdata = {ct_entry({wb_adr_i[8:2], 1'b0}), ct_entry({wb_adr_i[8:2], 1'b1})};
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_ack_o   <= 1'b0;
            wb_err_o   <= 1'b0;
            wb_dat_o   <= '0;
            cdc_conf   <= CDC_DEFAULT;
            cdc_enable <= 1'b0;
            lfsr       <= SEED_INIT;
            cycle_cnt  <= '0;
            for (int unsigned k = 0; k < 16; k++) scratch[k] <= '0;
        end else begin
            wb_ack_o   <= req & dec_ok;
            wb_err_o   <= req & ~dec_ok;
            wb_dat_o   <= (req && dec_ok && !wb_we_i) ? dec_rdata : '0;
            cycle_cnt  <= cycle_cnt + 32'd1;
            cdc_enable <= req & wr_cdc;
            if (req && wr_cdc) cdc_conf <= wb_dat_i[2:0];
            // a seed write replaces the shift for that cycle; zero would lock the LFSR
            if (req && wr_seed) lfsr <= (wb_dat_i == '0) ? SEED_INIT : wb_dat_i;
            else                lfsr <= lfsr_step;
            if (req && wr_scr) begin
                for (int unsigned b = 0; b < 4; b++) begin
                    if (wb_sel_i[b]) scratch[wb_adr_i[5:2]][8*b +: 8] <= wb_dat_i[8*b +: 8];
                end
            end
        end
    end

endmodule
